// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing controller with tick prescaler,
// synchronised request buttons, minimum-green guarantee and flashing night mode.
module ped_crossing_ctrl #(
   parameter int CLK_PER_TICK = 12000,
   parameter int TW           = 16,
   parameter int N_BTN        = 2,
   parameter int T_MIN_GREEN  = 5,
   parameter int T_YELLOW     = 2,
   parameter int T_CLEAR      = 1,
   parameter int T_WALK       = 10,
   parameter int T_FLASH      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] button,
   input  logic             night,
   output logic             car_red,
   output logic             car_yellow,
   output logic             car_green,
   output logic             ped_red,
   output logic             ped_green,
   output logic             wait_lamp,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_GREEN  = 3'd0,
      S_YELLOW = 3'd1,
      S_CLEAR  = 3'd2,
      S_WALK   = 3'd3,
      S_FLASH  = 3'd4,
      S_NIGHT  = 3'd5
   } state_t;

   localparam logic [TW-1:0] PRESC_LAST  = TW'(CLK_PER_TICK - 1);
   localparam logic [TW-1:0] PHASE_MAX   = '1;
   localparam logic [TW-1:0] MIN_GREEN   = TW'(T_MIN_GREEN);
   localparam logic [TW-1:0] YELLOW_LAST = TW'(T_YELLOW - 1);
   localparam logic [TW-1:0] CLEAR_LAST  = TW'(T_CLEAR - 1);
   localparam logic [TW-1:0] WALK_LAST   = TW'(T_WALK - 1);
   localparam logic [TW-1:0] FLASH_LAST  = TW'(T_FLASH - 1);

   state_t           state_q, state_d;
   logic [N_BTN-1:0] btn_s1_q, btn_s1_d;
   logic [N_BTN-1:0] btn_s2_q, btn_s2_d;
   logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
   logic             night_s1_q, night_s1_d;
   logic             night_s2_q, night_s2_d;
   logic [TW-1:0]    presc_q, presc_d;
   logic [TW-1:0]    phase_q, phase_d;
   logic             req_q, req_d;
   logic             from_night_q, from_night_d;
   logic             car_red_q, car_red_d;
   logic             car_yellow_q, car_yellow_d;
   logic             car_green_q, car_green_d;
   logic             ped_red_q, ped_red_d;
   logic             ped_green_q, ped_green_d;

   logic             tick;
   logic             btn_rise;
   logic             transition;
   logic             accept_req;
   logic [TW-1:0]    phase_inc;

   always_comb begin
      btn_s1_d   = button;
      btn_s2_d   = btn_s1_q;
      btn_prev_d = btn_s2_q;
      night_s1_d = night;
      night_s2_d = night_s1_q;

      tick      = (presc_q == PRESC_LAST);
      btn_rise  = |(btn_s2_q & ~btn_prev_q);
      phase_inc = (tick && (phase_q != PHASE_MAX)) ? phase_q + TW'(1) : phase_q;

      state_d      = state_q;
      from_night_d = from_night_q;

      // Timed exits fire on the tick that completes the last phase, so every
      // timed state lasts exactly T_x ticks from its entry edge.
      case (state_q)
         S_GREEN: begin
            if (night_s2_q) begin
               state_d = S_NIGHT;
            end else if (req_q && (phase_inc >= MIN_GREEN)) begin
               state_d = S_YELLOW;
            end
         end
         S_YELLOW: begin
            if (tick && (phase_q == YELLOW_LAST)) begin
               state_d      = S_CLEAR;
               from_night_d = 1'b0;
            end
         end
         S_CLEAR: begin
            if (tick && (phase_q == CLEAR_LAST)) begin
               state_d = from_night_q ? S_GREEN : S_WALK;
            end
         end
         S_WALK: begin
            if (tick && (phase_q == WALK_LAST)) begin
               state_d = S_FLASH;
            end
         end
         S_FLASH: begin
            if (tick && (phase_q == FLASH_LAST)) begin
               state_d = S_GREEN;
            end
         end
         S_NIGHT: begin
            if (!night_s2_q) begin
               state_d      = S_CLEAR;
               from_night_d = 1'b1;
            end
         end
         default: state_d = S_GREEN;
      endcase

      transition = (state_d != state_q);
      presc_d    = (transition || tick) ? '0 : presc_q + TW'(1);
      phase_d    = transition ? '0 : phase_inc;

      // Requests latch only while cars still own the road; entering WALK
      // serves the request and entering NIGHT discards it.
      accept_req = ((state_q == S_GREEN) || (state_q == S_YELLOW) || (state_q == S_CLEAR))
                   && (state_d != S_WALK) && (state_d != S_NIGHT);
      req_d      = accept_req ? (req_q | btn_rise) : 1'b0;

      car_red_d    = 1'b0;
      car_yellow_d = 1'b0;
      car_green_d  = 1'b0;
      ped_red_d    = 1'b0;
      ped_green_d  = 1'b0;
      case (state_d)
         S_YELLOW: begin
            car_yellow_d = 1'b1;
            ped_red_d    = 1'b1;
         end
         S_CLEAR: begin
            car_red_d = 1'b1;
            ped_red_d = 1'b1;
         end
         S_WALK: begin
            car_red_d   = 1'b1;
            ped_green_d = 1'b1;
         end
         S_FLASH: begin
            car_red_d   = 1'b1;
            ped_green_d = ~phase_d[0];
         end
         S_NIGHT: begin
            car_yellow_d = ~phase_d[0];
         end
         default: begin
            car_green_d = 1'b1;
            ped_red_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_GREEN;
         btn_s1_q     <= '0;
         btn_s2_q     <= '0;
         btn_prev_q   <= '0;
         night_s1_q   <= 1'b0;
         night_s2_q   <= 1'b0;
         presc_q      <= '0;
         phase_q      <= '0;
         req_q        <= 1'b0;
         from_night_q <= 1'b0;
         car_red_q    <= 1'b0;
         car_yellow_q <= 1'b0;
         car_green_q  <= 1'b1;
         ped_red_q    <= 1'b1;
         ped_green_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         btn_s1_q     <= btn_s1_d;
         btn_s2_q     <= btn_s2_d;
         btn_prev_q   <= btn_prev_d;
         night_s1_q   <= night_s1_d;
         night_s2_q   <= night_s2_d;
         presc_q      <= presc_d;
         phase_q      <= phase_d;
         req_q        <= req_d;
         from_night_q <= from_night_d;
         car_red_q    <= car_red_d;
         car_yellow_q <= car_yellow_d;
         car_green_q  <= car_green_d;
         ped_red_q    <= ped_red_d;
         ped_green_q  <= ped_green_d;
      end
   end

   assign car_red    = car_red_q;
   assign car_yellow = car_yellow_q;
   assign car_green  = car_green_q;
   assign ped_red    = ped_red_q;
   assign ped_green  = ped_green_q;
   assign wait_lamp  = req_q;
   assign state      = state_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - bench for ped_crossing_ctrl against a cycle-count
// reference model of the crossing rules.
module tb_ped_crossing_ctrl;

   localparam int CPT  = 4;
   localparam int TW   = 16;
   localparam int NB   = 2;
   localparam int TMIN = 3;
   localparam int TY   = 2;
   localparam int TC   = 1;
   localparam int TWK  = 4;
   localparam int TF   = 2;

   localparam logic [8:0] RESET_OUT = {3'd0, 5'b00110, 1'b0};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NB-1:0] button = '0;
   logic          night = 1'b0;
   logic          car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp;
   logic [2:0]    state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int            m_state;
   int            m_t;
   bit            m_req;
   bit            m_from_night;
   logic [NB-1:0] hb1, hb2, hb3;
   logic          hn1, hn2;

   ped_crossing_ctrl #(
      .CLK_PER_TICK(CPT), .TW(TW), .N_BTN(NB), .T_MIN_GREEN(TMIN),
      .T_YELLOW(TY), .T_CLEAR(TC), .T_WALK(TWK), .T_FLASH(TF)
   ) dut (
      .clk(clk), .rst(rst), .button(button), .night(night),
      .car_red(car_red), .car_yellow(car_yellow), .car_green(car_green),
      .ped_red(ped_red), .ped_green(ped_green), .wait_lamp(wait_lamp),
      .state(state)
   );

   always #5 clk = ~clk;

   assert property (@(negedge clk) disable iff (rst) !(car_green && ped_green));

   function automatic int dur_cycles(input int s);
      case (s)
         1: return TY * CPT;
         2: return TC * CPT;
         3: return TWK * CPT;
         4: return TF * CPT;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_t = 0; m_req = 0; m_from_night = 0;
      hb1 = '0; hb2 = '0; hb3 = '0; hn1 = 0; hn2 = 0;
   endtask

   // Inputs become visible two edges after sampling; a button edge is a
   // sampled 0 followed by a sampled 1.
   task automatic model_step();
      logic rise, nsync;
      int   nxt;
      bit   acc;
      rise = |(hb2 & ~hb3);
      nsync = hn2;
      nxt = m_state;
      case (m_state)
         0: begin
            if (nsync) nxt = 5;
            else if (m_req && (m_t + 1 >= TMIN * CPT)) nxt = 1;
         end
         1: if (m_t + 1 == dur_cycles(1)) begin nxt = 2; m_from_night = 0; end
         2: if (m_t + 1 == dur_cycles(2)) nxt = m_from_night ? 0 : 3;
         3: if (m_t + 1 == dur_cycles(3)) nxt = 4;
         4: if (m_t + 1 == dur_cycles(4)) nxt = 0;
         default: if (!nsync) begin nxt = 2; m_from_night = 1; end
      endcase
      acc = (m_state <= 2) && (nxt != 3) && (nxt != 5);
      m_req = acc ? (m_req | rise) : 1'b0;
      m_t = (nxt != m_state) ? 0 : m_t + 1;
      m_state = nxt;
      hb3 = hb2; hb2 = hb1; hb1 = button;
      hn2 = hn1; hn1 = night;
   endtask

   function automatic logic [8:0] model_out();
      logic cr, cy, cg, pr, pg;
      bit even;
      even = ((m_t / CPT) % 2) == 0;
      {cr, cy, cg, pr, pg} = 5'b0;
      case (m_state)
         0: begin cg = 1; pr = 1; end
         1: begin cy = 1; pr = 1; end
         2: begin cr = 1; pr = 1; end
         3: begin cr = 1; pg = 1; end
         4: begin cr = 1; pg = even; end
         default: cy = even;
      endcase
      return {3'(m_state), cr, cy, cg, pr, pg, m_req};
   endfunction

   task automatic cycle();
      logic [8:0] exp_v, act_v;
      int ncar;
      @(posedge clk);
      if (rst) begin
         model_reset();
         cyc = 0;
      end else begin
         model_step();
         cyc++;
      end
      @(negedge clk);
      exp_v = model_out();
      act_v = {state, car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp};
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL model_cycle cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
      end
      ncar = int'(car_red) + int'(car_yellow) + int'(car_green);
      total++;
      if ((car_green && ped_green) || (state != 3'd5 && ncar != 1)) begin
         bad++;
         $display("FAIL safety cyc=%0d got cg=%b pg=%b ncar=%0d want exclusive and one car lamp",
                  cyc, car_green, ped_green, ncar);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; button = '0; night = 1'b0;
      model_reset();
      repeat (2) cycle();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_state(input logic [2:0] code, input int budget, output bit found);
      found = (state === code);
      for (int i = 0; i < budget && !found; i++) begin
         cycle();
         if (state === code) found = 1;
      end
   endtask

   task automatic press(input logic [NB-1:0] b);
      button = b;
      cycle();
      button = '0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++;
      if ({state, car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp} !== RESET_OUT) begin
         bad++;
         $display("FAIL reset_values got=%b want=%b",
                  {state, car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp}, RESET_OUT);
      end
      do_reset();
   endtask

   task automatic test_basic_cycle();
      int cnt[8];
      logic [7:0] fpat;
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      fpat = '0;
      do_reset();
      while (cyc < 40) cycle();
      press(2'b01);
      while (cyc < 43) cycle();
      total++;
      if ({state, wait_lamp} !== {3'd0, 1'b1}) begin
         bad++;
         $display("FAIL basic_wait_at_43 got=%b want=%b", {state, wait_lamp}, {3'd0, 1'b1});
      end
      cycle();
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL basic_yellow_at_44 got=%0d want=1", state);
      end
      while (cyc < 80) begin
         cnt[state]++;
         if (state == 3'd4) fpat = {fpat[6:0], ped_green};
         cycle();
      end
      total++;
      if ({cnt[1], cnt[2], cnt[3], cnt[4]} !== {32'd8, 32'd4, 32'd16, 32'd8}) begin
         bad++;
         $display("FAIL basic_durations got=%0d/%0d/%0d/%0d want=8/4/16/8", cnt[1], cnt[2], cnt[3], cnt[4]);
      end
      total++;
      if (fpat !== 8'hF0) begin
         bad++;
         $display("FAIL basic_flash_pattern got=%b want=11110000", fpat);
      end
      total++;
      if ({state, wait_lamp} !== {3'd0, 1'b0}) begin
         bad++;
         $display("FAIL basic_back_to_green got=%b want=0000", {state, wait_lamp});
      end
   endtask

   task automatic test_early_press();
      bit f;
      do_reset();
      repeat (2) cycle();
      press(2'b01);
      while (cyc < 11) cycle();
      total++;
      if (state !== 3'd0) begin
         bad++;
         $display("FAIL early_green_at_11 got=%0d want=0", state);
      end
      cycle();
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL early_yellow_at_12 got=%0d want=1", state);
      end
      wait_state(3'd0, 60, f);
   endtask

   task automatic test_held_button();
      int ye;
      logic [2:0] prev;
      ye = 0;
      do_reset();
      prev = state;
      button[1] = 1'b1;
      for (int i = 0; i < 160; i++) begin
         if (i == 100) button[1] = 1'b0;
         cycle();
         if (prev !== 3'd1 && state === 3'd1) ye++;
         prev = state;
      end
      total++;
      if (ye != 1) begin
         bad++;
         $display("FAIL held_single_request got=%0d want=1", ye);
      end
      total++;
      if ({state, wait_lamp} !== 4'b0000) begin
         bad++;
         $display("FAIL held_idle_after got=%b want=0000", {state, wait_lamp});
      end
   endtask

   task automatic test_press_in_walk();
      bit f;
      int nonzero, wl;
      nonzero = 0; wl = 0;
      do_reset();
      press(2'b01);
      wait_state(3'd3, 60, f);
      total++;
      if (!f) begin
         bad++;
         $display("FAIL walk_reach got=%0d want=3", state);
      end
      repeat (3) cycle();
      press(2'b11);
      wait_state(3'd0, 80, f);
      total++;
      if (!f) begin
         bad++;
         $display("FAIL walk_return got=%0d want=0", state);
      end
      repeat (40) begin
         cycle();
         if (state !== 3'd0) nonzero++;
         if (wait_lamp !== 1'b0) wl++;
      end
      total++;
      if ({nonzero, wl} !== {32'd0, 32'd0}) begin
         bad++;
         $display("FAIL walk_press_ignored got=%0d/%0d want=0/0", nonzero, wl);
      end
   endtask

   task automatic test_night();
      bit f;
      logic [15:0] pat;
      int ped_bad, wl_bad, clr;
      ped_bad = 0; wl_bad = 0; clr = 0;
      do_reset();
      repeat (15) cycle();
      night = 1'b1;
      repeat (3) cycle();
      total++;
      if (state !== 3'd5) begin
         bad++;
         $display("FAIL night_entry got=%0d want=5", state);
      end
      pat = {15'b0, car_yellow};
      for (int i = 1; i < 16; i++) begin
         button[0] = (i % 4 == 1);
         cycle();
         pat = {pat[14:0], car_yellow};
         if (ped_red || ped_green) ped_bad++;
         if (wait_lamp) wl_bad++;
      end
      button = '0;
      repeat (5) cycle();
      total++;
      if (pat !== 16'hF0F0) begin
         bad++;
         $display("FAIL night_blink got=%h want=f0f0", pat);
      end
      total++;
      if ({ped_bad, wl_bad} !== {32'd0, 32'd0}) begin
         bad++;
         $display("FAIL night_ped_wait got=%0d/%0d want=0/0", ped_bad, wl_bad);
      end
      night = 1'b0;
      wait_state(3'd2, 10, f);
      total++;
      if (!f) begin
         bad++;
         $display("FAIL night_exit_clear got=%0d want=2", state);
      end
      while (state === 3'd2 && clr < 10) begin
         clr++;
         cycle();
      end
      total++;
      if (clr != 4) begin
         bad++;
         $display("FAIL night_clear_len got=%0d want=4", clr);
      end
      total++;
      if ({state, wait_lamp} !== 4'b0000) begin
         bad++;
         $display("FAIL night_to_green got=%b want=0000", {state, wait_lamp});
      end
   endtask

   task automatic test_reset_in_walk();
      bit f;
      do_reset();
      press(2'b10);
      wait_state(3'd3, 60, f);
      repeat (3) cycle();
      rst = 1'b1;
      #1;
      total++;
      if ({state, car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp} !== RESET_OUT) begin
         bad++;
         $display("FAIL async_reset_walk got=%b want=%b",
                  {state, car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp}, RESET_OUT);
      end
      model_reset();
      repeat (2) cycle();
      rst = 1'b0;
      cyc = 0;
      press(2'b01);
      wait_state(3'd1, 40, f);
      total++;
      if (!f) begin
         bad++;
         $display("FAIL reset_resume_yellow got=%0d want=1", state);
      end
      wait_state(3'd0, 60, f);
      total++;
      if (!f) begin
         bad++;
         $display("FAIL reset_resume_green got=%0d want=0", state);
      end
   endtask

   task automatic test_random();
      int btn_left;
      btn_left = 0;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         if (btn_left > 0) begin
            btn_left--;
            if (btn_left == 0) button = '0;
         end else if ($urandom_range(0, 24) == 0) begin
            button = NB'($urandom_range(1, (1 << NB) - 1));
            btn_left = $urandom_range(1, 5);
         end
         if ($urandom_range(0, 199) == 0) night = ~night;
         cycle();
      end
      button = '0;
      night = 1'b0;
      repeat (60) cycle();
   endtask

   initial begin
      test_reset();
      test_basic_cycle();
      test_early_press();
      test_held_button();
      test_press_in_walk();
      test_night();
      test_reset_in_walk();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
